// File: rtl/reg_file_dump.sv
// Register-file read sweeper: streams every (index, data) pair on a valid/ready port.
// Optional checksum output is enabled with `define REG_DUMP_CHECKSUM_EN.
module reg_file_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                  r_state, w_state;
    logic [ADDR_WIDTH-1:0]   r_raddr, w_raddr;
    logic [ADDR_WIDTH-1:0]   r_out_idx, w_out_idx;
    logic [DATA_WIDTH-1:0]   r_out_data, w_out_data;
    logic                    r_out_valid, w_out_valid;
    logic                    r_out_last, w_out_last;
    logic                    r_busy, w_busy;
    logic                    r_done, w_done;
    logic                    w_hs;
    logic                    w_start;

    assign w_hs    = r_out_valid & out_ready;
    // A start coinciding with the done pulse is dropped; the next cycle may start again.
    assign w_start = start & ~r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_raddr     <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_raddr     <= w_raddr;
            r_out_idx   <= w_out_idx;
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
            r_out_last  <= w_out_last;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_raddr     = r_raddr;
        w_out_idx   = r_out_idx;
        w_out_data  = r_out_data;
        w_out_valid = r_out_valid;
        w_out_last  = r_out_last;
        w_busy      = r_busy;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_raddr = '0;
                if (w_start) begin
                    // rdata already reflects address 0, so word 0 is captured right away.
                    w_out_idx   = '0;
                    w_out_data  = rdata;
                    w_out_last  = (MAX == '0);
                    w_out_valid = 1'b1;
                    w_busy      = 1'b1;
                    w_raddr     = ONE;
                    w_state     = S_SEND;
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    if (r_out_idx == MAX) begin
                        w_out_valid = 1'b0;
                        w_out_last  = 1'b0;
                        w_busy      = 1'b0;
                        w_raddr     = '0;
                        w_done      = 1'b1;
                        w_state     = S_IDLE;
                    end else begin
                        w_out_idx  = r_raddr;
                        w_out_data = rdata;
                        w_out_last = (r_raddr == MAX);
                        w_raddr    = r_raddr + ONE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum, w_checksum;

    always_comb begin
        w_checksum = r_checksum;
        if (r_state == S_IDLE && w_start)
            w_checksum = '0;
        else if (r_state == S_SEND && w_hs)
            w_checksum = r_checksum ^ r_out_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_checksum <= '0;
        else      r_checksum <= w_checksum;
    end

    assign checksum = r_checksum;
`endif

    assign raddr     = r_raddr;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump with a behavioural 32x32 register file on the read port.
module tb_reg_file_dump;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          out_ready;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] mem [N];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rdata = mem[raddr];

    reg_file_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .raddr(raddr), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
`ifdef REG_DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_raddr"}, raddr,     '0);
        check({tag, "_done"},  done,      1'b0);
    endtask

    // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: stray starts at idx 10 and in the done cycle;
    // 3: reset at idx 17
    task automatic dump(input int mode, input logic [DW-1:0] exp_ck);
        int   exp_i = 0;
        int   cyc = 0;
        int   busy_cnt = 0;
        bit   aborted = 0;
        logic rdy;
        start = 1'b1;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        while (exp_i < N && cyc < 400 && !aborted) begin
            check("valid", out_valid, 1'b1);
            check("busy", busy, 1'b1);
            if (busy) busy_cnt++;
            check("idx", out_idx, exp_i[AW-1:0]);
            check("data", out_data, mem[exp_i]);
            check("last", out_last, (exp_i == N-1));
            if (mode == 3 && exp_i == 17) begin
                #2 rst = 1'b0;
                #1;
                check_quiet("abort");
                check("abort_idx", out_idx, '0);
                check("abort_data", out_data, '0);
                check("abort_last", out_last, 1'b0);
                step();
                check_quiet("abort_hold");
                rst = 1'b1;
                out_ready = 1'b0;
                step();
                check_quiet("abort_after");
                aborted = 1;
            end else begin
                rdy = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
                out_ready = rdy;
                start = (mode == 2 && exp_i == 10);
                step();
                cyc++;
                if (rdy) exp_i++;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            check("word_count", exp_i, N);
            out_ready = 1'b0;
            check("done_pulse", done, 1'b1);
            check_quiet_nodone("after_last");
            if (mode == 0) check("busy_cycles", busy_cnt, N);
`ifdef REG_DUMP_CHECKSUM_EN
            check("checksum", checksum, exp_ck);
`endif
            if (mode == 2) start = 1'b1;
            step();
            check_quiet("done_next");
`ifdef REG_DUMP_CHECKSUM_EN
            check("checksum_hold", checksum, exp_ck);
`endif
        end
    endtask

    task automatic check_quiet_nodone(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_raddr"}, raddr,     '0);
        check({tag, "_last"},  out_last,  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) mem[i] = i * 32'h01010101;
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check("reset_idx", out_idx, '0);
        check("reset_data", out_data, '0);
        check("reset_last", out_last, 1'b0);
`ifdef REG_DUMP_CHECKSUM_EN
        check("reset_checksum", checksum, '0);
`endif
        rst = 1'b1;
        step();
        step();
        check_quiet("idle");

        // Asynchronous reset mid-cycle while start is held high.
        start = 1'b1;
        step();
        check("pre_abort_valid", out_valid, 1'b1);
        check("pre_abort_raddr", raddr, 5'd1);
        #2 rst = 1'b0;
        #1;
        check_quiet("async_rst");
        check("async_rst_last", out_last, 1'b0);
        step();
        check("rst_hold_valid", out_valid, 1'b0);
        rst = 1'b1;
        start = 1'b0;
        step();
        step();
        check_quiet("post_rst_idle");

        dump(0, 32'h0);
        dump(1, 32'h0);
        dump(2, 32'h0);
        dump(0, 32'h0);
        dump(3, 32'h0);
        dump(0, 32'h0);
        mem[5] = 32'hDEADBEEF;
        dump(0, 32'hDBA8BBEA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_file_dump.md
Name: reg_file_dump

Overview:
Read-side sweeper for the 32x32 register file. On a start pulse it drives the register file read port through every address, 0 to 2^ADDR_WIDTH-1. Each word is emitted on a valid/ready stream as an (index, data) pair with a last flag. It feeds debug/trace capture and end-of-test register dumps, and uses one read port of the register file, which has a combinational read.

Parameters:
DATA_WIDTH, 32, register word width
ADDR_WIDTH, 5, register address width; 2^ADDR_WIDTH registers are swept

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, active-low, asynchronous
start  input  1  begin a dump; sampled only in IDLE
raddr  output  ADDR_WIDTH  register file read address
rdata  input  DATA_WIDTH  register file read data, combinational from raddr
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts the word
out_idx  output  ADDR_WIDTH  register index of the current word
out_data  output  DATA_WIDTH  register contents
out_last  output  1  high with the word for index 2^ADDR_WIDTH-1
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. raddr=0, out_valid=0, out_idx=0, out_data=0, out_last=0, busy=0, done=0.
- All outputs are registered. A handshake occurs when out_valid=1 and out_ready=1 at a rising edge.
- States: IDLE, SEND.
- IDLE:
  - raddr holds 0.
  - On start=1: capture out_data<=rdata (register 0) and out_idx<=0; set out_valid<=1 and busy<=1; raddr<=1; go to SEND.
- SEND, no handshake: out_valid, out_idx, out_data and out_last are held stable. raddr is held.
- SEND, handshake with out_idx != MAX (MAX = 2^ADDR_WIDTH-1):
  - out_idx<=raddr, out_data<=rdata.
  - out_last<=(raddr==MAX).
  - raddr<=raddr+1, wrapping modulo 2^ADDR_WIDTH.
  - out_valid stays 1, giving a throughput of 1 word per cycle.
- SEND, handshake with out_idx==MAX:
  - out_valid<=0, out_last<=0, busy<=0, raddr<=0.
  - done<=1 for exactly one cycle; go to IDLE.
- Data is sampled in the capture cycle. A register file write in the same cycle is not visible, because the register file write is synchronous; later writes to already-captured indices are not reflected.
- start while busy, or in the cycle done=1, is ignored. start in IDLE on the cycle after done begins a new dump.
- out_ready is don't-care while out_valid=0.
- A dump always emits exactly 2^ADDR_WIDTH words, in ascending index order, with no gaps or repeats.
- Reset mid-dump aborts immediately to the reset values. No done pulse is generated.

Optional Feature:
REG_DUMP_CHECKSUM_EN
- Defined:
  - Adds output port checksum, width DATA_WIDTH.
  - The checksum register is cleared to 0 on start in IDLE.
  - On each handshake it becomes checksum XOR out_data.
  - Its final value is stable from the cycle done=1 until the next start. Reset value is 0.
- Undefined: the port and its register are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: assert rst=0 mid-cycle with start=1 -> all outputs 0 immediately; after release, no activity until start.
- Full dump, out_ready=1: preload reg[i]=i*0x01010101 (reg[0] reads 0), pulse start -> 32 consecutive valid cycles with out_idx 0..31 and data matching; out_last only at idx 31; done pulse 1 cycle after the last handshake; busy high for 32 cycles.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_idx/out_data are held during stalls; sequence stays 0..31 with no skip or duplicate; done follows the 32nd handshake.
- start reasserted at idx 10 and in the done cycle -> ignored; exactly 32 words; start on the following cycle begins a new dump at idx 0.
- Reset at idx 17 -> out_valid=0, raddr=0, no done pulse; a new start dumps from idx 0.
- REG_DUMP_CHECKSUM_EN defined, with the preload above -> checksum = XOR of i*0x01010101 for i=1..31 = 0x00000000; with reg[5]=0xDEADBEEF instead -> checksum = 0xDEADBEEF XOR 0x05050505 = 0xDBA8BBEA.
